bcd_bin_dl: RTL and testbench
=============================

Name: bcd_bin_dl

Overview:
Sequential BCD-to-binary converter using reverse double-dabble: shift right one bit per cycle, then subtract 3 from each BCD digit that is >= 8. It is the inverse of the team's serial binary-to-BCD converter. It turns packed-BCD values (operator-entered level or score presets, decimal counters) back into binary for game logic. It uses a start/busy/done handshake, and invalid BCD input is flagged with an error instead of being converted.

Parameters:
DIGITS, 4, number of packed BCD digits at input (input width 4*DIGITS)
BIN_W, 14, binary result width and shift iteration count; must satisfy 2^BIN_W > 10^DIGITS - 1 (14 for 4 digits)

Ports:
clk  in  1  system clock, all state on rising edge
rst_n  in  1  asynchronous active-low reset
gen  in  1  start request, sampled only in IDLE
bcd  in  4*DIGITS  packed BCD operand, digit 0 in [3:0], sampled on the accepting edge
bin  out  BIN_W  binary result, held until the next accepted gen
busy  out  1  high while a conversion is in progress
done  out  1  one-cycle pulse when bin/err are updated
err  out  1  high if the last accepted operand had any nibble > 9; held with bin

Behaviour:
- Reset (async, rst_n=0): state=IDLE, cnt=0, bin=0, busy=0, done=0, err=0, working registers=0. Takes effect immediately, including mid-conversion. Any in-progress conversion is abandoned and nothing is reported.
- FSM states: IDLE, SHIFT. busy = (state==SHIFT).
- IDLE:
  - gen=1 at edge k: latch bcd into working register W (4*DIGITS bits), clear shift register S (BIN_W bits), cnt=0.
  - If any nibble of bcd > 9: stay IDLE. At edge k, bin<=0, err<=1, done<=1 (error latency 1 edge).
  - Otherwise go to SHIFT.
- SHIFT, each edge:
  - {W,S} <= {W,S} >> 1; the LSB of W enters the MSB of S.
  - Then every digit of the shifted W that is >= 8 gets 3 subtracted. Correction is combinational on the shifted value and is registered in the same edge.
  - cnt <= cnt+1.
- Completion: on the shift edge where cnt==BIN_W-1 (i.e. the BIN_W-th shift, edge k+BIN_W), bin <= shifted S, err<=0, done<=1, state<=IDLE.
  - Latency for valid input: done visible BIN_W cycles after the accepting edge.
  - W is all zeros at that point for any valid operand.
- done is high for exactly one cycle, then 0. bin and err hold until the next accepted gen produces a new done.
- gen while busy=1: ignored, no effect on the current conversion.
- gen in the cycle where done=1: the FSM is already IDLE, so the request is accepted. Back-to-back conversions run with no dead cycle.
- gen held high continuously: a new conversion starts each time the FSM returns to IDLE.
- bcd may change freely after the accepting edge.
- Arithmetic:
  - Digit correction is 4-bit unsigned; values are 8..12 before subtraction, so there is no underflow.
  - The result is exact for 0..10^DIGITS-1.
  - cnt width is clog2(BIN_W+1).

Decomposition:
- Shared package: FSM state encoding (IDLE, SHIFT), BCD digit-width constant (4), digit-max constant (9), correction threshold (8) and correction amount (3).
- One natural sub-module: bcd_sub3, a combinational single-digit corrector (in 4-bit digit, out digit-3 if >= 8, else unchanged). Instantiate it DIGITS times via generate.

Test Plan:
- Reset, then gen with bcd=0x0000 -> done 14 cycles later, bin=0, err=0; busy high for exactly 14 cycles.
- gen with bcd=0x1234 -> done at accept+14, bin=1234 (0x04D2), err=0.
- gen with bcd=0x9999 -> bin=9999 (0x270F), err=0. Then gen with bcd=0x0001 in the same cycle as done -> second done 14 cycles later, bin=1.
- gen with bcd=0x12A4 -> done at accept+1, bin=0, err=1, busy never asserted. A following valid gen with 0x0042 -> bin=42, err=0.
- gen with 0x0500, then gen pulses with 0x9999 at accept+3 and accept+7 -> single done at accept+14, bin=500.
- gen with 0x8765, rst_n low at accept+6 -> bin=0, busy=0, done=0 immediately, no later done. After release, gen with 0x0010 -> bin=10.

Source files
------------

// File: rtl/bcd_bin_dl_pkg.sv
// bcd_bin_dl_pkg: shared state encoding and BCD digit constants for the BCD-to-binary converter.
package bcd_bin_dl_pkg;
  typedef enum logic {IDLE, SHIFT} state_t;
  localparam int DW = 4;
  localparam int DMAX = 9;
  localparam int THR = 8;
  localparam int SUB = 3;
endpackage

// File: rtl/bcd_bin_dl_sub3.sv
// bcd_bin_dl_sub3: single-digit reverse double-dabble corrector, subtracts 3 from digits >= 8.
module bcd_bin_dl_sub3
  import bcd_bin_dl_pkg::*;
(
  input  logic [DW-1:0] d,
  output logic [DW-1:0] q
);
  assign q = d >= DW'(THR) ? d - DW'(SUB) : d;
endmodule

// File: rtl/bcd_bin_dl.sv
// bcd_bin_dl: serial BCD-to-binary converter using reverse double-dabble with start/busy/done handshake.
module bcd_bin_dl
  import bcd_bin_dl_pkg::*;
#(
  parameter int DIGITS = 4,
  parameter int BIN_W = 14
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 gen,
  input  logic [DW*DIGITS-1:0] bcd,
  output logic [BIN_W-1:0]     bin,
  output logic                 busy,
  output logic                 done,
  output logic                 err
);
  localparam int BW = DW * DIGITS;
  localparam int CW = $clog2(BIN_W + 1);
  state_t state, nxt;
  logic [BW-1:0] w, w_sh, w_cor;
  logic [BIN_W-1:0] s, s_sh;
  logic [CW-1:0] cnt;
  logic [DIGITS-1:0] bad_d;
  logic bad, last;
  assign {w_sh, s_sh} = {w, s} >> 1;
  for (genvar i = 0; i < DIGITS; i++) begin : g_dig
    bcd_bin_dl_sub3 u_sub3 (.d(w_sh[DW*i +: DW]), .q(w_cor[DW*i +: DW]));
    assign bad_d[i] = bcd[DW*i +: DW] > DW'(DMAX);
  end
  assign bad = |bad_d;
  assign last = cnt == CW'(BIN_W - 1);
  assign busy = state == SHIFT;
  always_comb begin
    nxt = state == IDLE ? (gen && !bad ? SHIFT : IDLE) : (last ? IDLE : SHIFT);
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      w <= '0;
      s <= '0;
      cnt <= '0;
      bin <= '0;
      done <= 1'b0;
      err <= 1'b0;
    end else begin
      state <= nxt;
      done <= 1'b0;
      if (state == IDLE && gen) begin
        w <= bcd;
        s <= '0;
        cnt <= '0;
        if (bad) begin
          bin <= '0;
          err <= 1'b1;
          done <= 1'b1;
        end
      end else if (state == SHIFT) begin
        w <= w_cor;
        s <= s_sh;
        cnt <= cnt + 1'b1;
        if (last) begin
          bin <= s_sh;
          err <= 1'b0;
          done <= 1'b1;
        end
      end
    end
  end
endmodule

// File: tb/tb_bcd_bin_dl.sv
// tb_bcd_bin_dl: randomized and directed checks of bcd_bin_dl against a decimal-arithmetic reference.
module tb_bcd_bin_dl;
  logic clk = 0, rst_n = 0, gen = 0;
  logic [15:0] bcd = 0;
  logic [13:0] bin;
  logic busy, done, err;
  int total = 0, passed = 0;

  bcd_bin_dl dut (.clk(clk), .rst_n(rst_n), .gen(gen), .bcd(bcd), .bin(bin), .busy(busy), .done(done), .err(err));

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    if (obs !== exp) $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    else passed++;
  endtask

  function automatic bit is_bad(input logic [15:0] v);
    for (int i = 0; i < 4; i++) if (((v >> (4 * i)) & 16'hF) > 9) return 1;
    return 0;
  endfunction

  function automatic int dec(input logic [15:0] v);
    int r = 0, m = 1;
    for (int i = 0; i < 4; i++) begin
      r += int'((v >> (4 * i)) & 16'hF) * m;
      m *= 10;
    end
    return r;
  endfunction

  // Accept v on the next edge, then follow the conversion to its done pulse.
  task automatic go(input logic [15:0] v, input bit pulses);
    int n = 0, bc = 0;
    gen = 1;
    bcd = v;
    @(posedge clk); #1;
    gen = 0;
    bcd = 16'($urandom);
    while (!done && n < 40) begin
      if (busy) bc++;
      gen = pulses && (n == 2 || n == 6);
      if (gen) bcd = 16'h9999;
      @(posedge clk); #1;
      n++;
    end
    gen = 0;
    chk("latency", n, is_bad(v) ? 0 : 14);
    chk("busy_cycles", bc, is_bad(v) ? 0 : 14);
    chk("bin", bin, is_bad(v) ? 0 : dec(v));
    chk("err", err, is_bad(v));
  endtask

  task automatic gap(input int c);
    for (int i = 0; i < c; i++) begin
      @(posedge clk); #1;
      if (i == 0) chk("done_pulse", done, 0);
    end
  endtask

  initial begin
    int dn;
    logic [15:0] v;
    #12;
    chk("rst_bin", bin, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_err", err, 0);
    @(negedge clk) rst_n = 1;
    @(posedge clk); #1;
    go(16'h0000, 0); gap(1);
    go(16'h1234, 0); gap(2);
    go(16'h9999, 0);
    go(16'h0001, 0); gap(1);
    go(16'h12A4, 0); gap(1);
    go(16'h0042, 0); gap(1);
    go(16'h0500, 1); gap(1);
    gen = 1;
    bcd = 16'h8765;
    @(posedge clk); #1;
    gen = 0;
    repeat (5) begin
      @(posedge clk); #1;
    end
    #2 rst_n = 0;
    #1;
    chk("arst_bin", bin, 0);
    chk("arst_busy", busy, 0);
    chk("arst_done", done, 0);
    chk("arst_err", err, 0);
    @(negedge clk) rst_n = 1;
    dn = 0;
    repeat (20) begin
      @(posedge clk); #1;
      dn += int'(done);
    end
    chk("no_done_after_rst", dn, 0);
    go(16'h0010, 0); gap(1);
    go(16'hF000, 0);
    go(16'h0009, 0); gap(1);
    for (int k = 0; k < 40; k++) begin
      v = 16'($urandom);
      if ($urandom_range(3) != 0)
        for (int i = 0; i < 4; i++) v[4*i +: 4] = 4'($urandom_range(9));
      go(v, bit'($urandom_range(1)));
      if ($urandom_range(1) != 0) gap($urandom_range(1, 3));
    end
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got 1 expected 0");
    $fatal(1);
  end
endmodule
